// File: rtl/data_memory_bytelane_if.sv
// Request/response bus for the byte-lane data memory.
// The master drives the request fields; the slave (memory) returns
// ready, the one-cycle response pulse, load data and the error flag.
interface data_memory_bytelane_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_size, req_signed, address, write_data,
        input  req_ready, resp_valid, read_data, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, address, write_data,
        output req_ready, resp_valid, read_data, resp_error
    );
endinterface

// File: rtl/data_memory_bytelane.sv
// Byte-addressed data memory for the Mini-MIPS datapath.
// Supports byte/half/word loads and stores (little-endian lanes), sign or
// zero extension on loads, a programmable wait latency before the array
// access, and reports misaligned / illegal-size accesses instead of
// performing them.
module data_memory_bytelane #(
    parameter int ADDR_BITS = 7,
    parameter int LATENCY   = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    data_memory_bytelane_if.slave  bus
);

    localparam int          DEPTH  = 1 << ADDR_BITS;
    localparam int          AW     = ADDR_BITS + 2;
    localparam logic [3:0]  LAT4   = 4'(LATENCY);

    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [3:0]      r_cnt;
    logic            r_write;
    logic            r_signed;
    logic [1:0]      r_size;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic [31:0]     r_mem [DEPTH];

    logic                 w_accept;
    logic                 w_access;
    logic                 w_error;
    logic [ADDR_BITS-1:0] w_idx;
    logic [1:0]           w_lane;
    logic [3:0]           w_be;
    logic [31:0]          w_wlanes;
    logic [31:0]          w_word;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_load;

    // Only upper address bits above the word index are dropped, so accesses wrap.
    assign w_idx    = r_addr[AW-1:2];
    assign w_lane   = r_addr[1:0];
    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);

    // Alignment / size legality of the captured request.
    always_comb begin
        w_error = 1'b0;
        case (r_size)
            SZ_BYTE: w_error = 1'b0;
            SZ_HALF: w_error = r_addr[0];
            SZ_WORD: w_error = (r_addr[1:0] != 2'b00);
            default: w_error = 1'b1;
        endcase
    end

    // Per-lane byte enable and store data: sub-word data is replicated so
    // every candidate lane sees the right byte, the enable picks the lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_be[gi] = (r_size == SZ_BYTE) ? (w_lane == 2'(gi)) :
                              (r_size == SZ_HALF) ? (w_lane[1] == 1'(gi / 2)) :
                              1'b1;
            assign w_wlanes[gi*8 +: 8] = (r_size == SZ_BYTE) ? r_wdata[7:0] :
                                         (r_size == SZ_HALF) ? r_wdata[(gi % 2)*8 +: 8] :
                                         r_wdata[gi*8 +: 8];
        end
    endgenerate

    // Load path: select the addressed byte/half and extend it.
    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_word[{w_lane[1], 4'b0000} +: 16];

    // Extension of the selected load data; word loads ignore the signed flag.
    always_comb begin
        w_load = w_word;
        case (r_size)
            SZ_BYTE: w_load = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            SZ_HALF: w_load = r_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one RESP cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_state_next = WAIT;
            WAIT:    if (r_cnt == 4'd0) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register; reset drops any pending request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request capture, wait counter and registered response fields.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= 4'd0;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write  <= bus.req_write;
                r_signed <= bus.req_signed;
                r_size   <= bus.req_size;
                r_addr   <= bus.address[AW-1:0];
                r_wdata  <= bus.write_data;
                r_cnt    <= LAT4;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_err   <= w_error;
                r_rdata <= (r_write || w_error) ? 32'd0 : w_load;
            end
        end
    end

    // Array write with byte enables; contents are never reset.
    always_ff @(posedge clock) begin
        if (w_access && r_write && !w_error) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= w_wlanes[i*8 +: 8];
                end
            end
        end
    end

    // Ready is forced low while reset is held.
    assign bus.req_ready  = reset_n && (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.read_data  = r_rdata;
    assign bus.resp_error = r_err;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Testbench for data_memory_bytelane: one instance with LATENCY=0/ADDR_BITS=7
// and one with LATENCY=3/ADDR_BITS=4, checked through an expected-result queue.
module tb_data_memory_bytelane;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n;
    logic rst3_n;

    data_memory_bytelane_if if0();
    data_memory_bytelane_if if3();

    data_memory_bytelane #(.ADDR_BITS(7), .LATENCY(0)) u_dut0 (
        .clock   (clk),
        .reset_n (rst0_n),
        .bus     (if0.slave)
    );

    data_memory_bytelane #(.ADDR_BITS(4), .LATENCY(3)) u_dut3 (
        .clock   (clk),
        .reset_n (rst3_n),
        .bus     (if3.slave)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        string       tag;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    int   acc0[$];
    int   acc3[$];
    int   resp_seen [2];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   low3 = 0;
    bit   trk3 = 1'b0;
    bit   b2b3 = 1'b0;
    int   last_acc3 = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? if0.req_ready : if3.req_ready;
    endfunction
    function automatic logic get_rv(input int d);
        return (d == 0) ? if0.resp_valid : if3.resp_valid;
    endfunction
    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? if0.read_data : if3.read_data;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 0) ? if0.resp_error : if3.resp_error;
    endfunction

    task automatic set_bus(input int d, input bit v, input bit wr, input logic [1:0] sz,
                           input bit sg, input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            if0.req_valid = v; if0.req_write = wr; if0.req_size = sz;
            if0.req_signed = sg; if0.address = a; if0.write_data = wd;
        end else begin
            if3.req_valid = v; if3.req_write = wr; if3.req_size = sz;
            if3.req_signed = sg; if3.address = a; if3.write_data = wd;
        end
    endtask

    task automatic do_req(input int d, input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] erd, input bit eerr, input string tag);
        exp_t e;
        bit   ok;
        e.rd = erd; e.err = eerr; e.tag = tag;
        if (d == 0) q0.push_back(e); else q3.push_back(e);
        @(posedge clk); #1;
        set_bus(d, 1'b1, wr, sz, sg, a, wd);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (get_ready(d)) begin ok = 1'b1; break; end
        end
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        set_bus(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (get_rv(d)) begin ok = 1'b1; break; end
        end
        chk({tag, "_resp_seen"}, 32'(ok), 32'd1);
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'(get_rv(d)), 32'd0);
        chk({tag, "_rd_hold"}, get_rd(d), erd);
        $display("txn dut%0d %s wr=%0d size=%0d signed=%0d addr=%h wdata=%h -> rd=%h err=%0d",
                 (d == 0) ? 0 : 3, tag, wr, sz, sg, a, wd, get_rd(d), get_err(d));
    endtask

    // Scoreboard/monitor for the LATENCY=0 instance.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (!rst0_n) begin
            acc0.delete();
        end else begin
            if (if0.req_valid && if0.req_ready) acc0.push_back(cyc);
            if (if0.resp_valid) begin
                resp_seen[0]++;
                chk("dut0_resp_expected", 32'(q0.size() != 0 && acc0.size() != 0), 32'd1);
                if (q0.size() != 0 && acc0.size() != 0) begin
                    e = q0.pop_front();
                    a = acc0.pop_front();
                    chk({e.tag, "_rd"}, if0.read_data, e.rd);
                    chk({e.tag, "_err"}, 32'(if0.resp_error), 32'(e.err));
                    chk({e.tag, "_latency"}, 32'(cyc - a), 32'd2);
                end
            end
        end
    end

    // Scoreboard/monitor for the LATENCY=3 instance, plus ready-low and spacing checks.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (!rst3_n) begin
            acc3.delete();
            trk3 = 1'b0;
            last_acc3 = -1;
        end else begin
            if (trk3 && if3.req_ready) begin
                chk("dut3_ready_low_cycles", 32'(low3), 32'd5);
                trk3 = 1'b0;
            end else if (trk3) begin
                low3++;
            end
            if (if3.req_valid && if3.req_ready) begin
                if (b2b3 && last_acc3 >= 0) chk("dut3_b2b_spacing", 32'(cyc - last_acc3), 32'd6);
                last_acc3 = cyc;
                acc3.push_back(cyc);
                trk3 = 1'b1;
                low3 = 0;
            end
            if (if3.resp_valid) begin
                resp_seen[1]++;
                chk("dut3_resp_expected", 32'(q3.size() != 0 && acc3.size() != 0), 32'd1);
                if (q3.size() != 0 && acc3.size() != 0) begin
                    e = q3.pop_front();
                    a = acc3.pop_front();
                    chk({e.tag, "_rd"}, if3.read_data, e.rd);
                    chk({e.tag, "_err"}, 32'(if3.resp_error), 32'(e.err));
                    chk({e.tag, "_latency"}, 32'(cyc - a), 32'd5);
                end
            end
        end
    end

    initial begin
        int cnt;
        int seen_before;
        resp_seen[0] = 0;
        resp_seen[1] = 0;
        set_bus(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        set_bus(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        rst0_n = 1'b0;
        rst3_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(get_ready(d)), 32'd0);
            chk("rst_resp_valid", 32'(get_rv(d)), 32'd0);
            chk("rst_read_data", get_rd(d), 32'd0);
            chk("rst_resp_error", 32'(get_err(d)), 32'd0);
        end
        @(posedge clk); #1;
        rst0_n = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);
        chk("dut0_ready_after_rst", 32'(if0.req_ready), 32'd1);
        chk("dut3_ready_after_rst", 32'(if3.req_ready), 32'd1);

        // LATENCY=0 instance: word, sub-word and misaligned accesses.
        do_req(0, 1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h0,        0, "st_w08");
        do_req(0, 0, 2'b10, 0, 32'h08, 32'h0,        32'hDEADBEEF, 0, "ld_w08");
        do_req(0, 0, 2'b00, 1, 32'h09, 32'h0,        32'hFFFFFFBE, 0, "ld_b09_s");
        do_req(0, 0, 2'b00, 0, 32'h09, 32'h0,        32'h000000BE, 0, "ld_b09_u");
        do_req(0, 0, 2'b01, 1, 32'h0A, 32'h0,        32'hFFFFDEAD, 0, "ld_h0A_s");
        do_req(0, 0, 2'b01, 0, 32'h08, 32'h0,        32'h0000BEEF, 0, "ld_h08_u");
        do_req(0, 1, 2'b00, 0, 32'h0B, 32'h12345677, 32'h0,        0, "st_b0B");
        do_req(0, 0, 2'b10, 0, 32'h08, 32'h0,        32'h77ADBEEF, 0, "ld_w08_b");
        do_req(0, 0, 2'b00, 1, 32'h0B, 32'h0,        32'h00000077, 0, "ld_b0B_s");
        do_req(0, 0, 2'b01, 1, 32'h08, 32'h0,        32'hFFFFBEEF, 0, "ld_h08_s");
        do_req(0, 1, 2'b10, 0, 32'h0A, 32'h11111111, 32'h0,        1, "st_w0A_mis");
        do_req(0, 0, 2'b10, 0, 32'h08, 32'h0,        32'h77ADBEEF, 0, "ld_w08_c");
        do_req(0, 0, 2'b01, 0, 32'h01, 32'h0,        32'h0,        1, "ld_h01_mis");
        do_req(0, 1, 2'b11, 0, 32'h08, 32'h22222222, 32'h0,        1, "st_sz3");
        do_req(0, 0, 2'b11, 0, 32'h08, 32'h0,        32'h0,        1, "ld_sz3");
        do_req(0, 0, 2'b10, 0, 32'h08, 32'h0,        32'h77ADBEEF, 0, "ld_w08_d");
        do_req(0, 1, 2'b01, 0, 32'h0A, 32'hAAAA5A5A, 32'h0,        0, "st_h0A");
        do_req(0, 0, 2'b10, 0, 32'h208, 32'h0,       32'h5A5ABEEF, 0, "ld_w208_wrap");

        // LATENCY=3 / depth-16 instance: aliasing, latency, back-to-back.
        do_req(1, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 32'h0,        0, "d3_st_w40");
        do_req(1, 0, 2'b10, 0, 32'h00, 32'h0,        32'hCAFEF00D, 0, "d3_ld_w00");
        do_req(1, 1, 2'b10, 0, 32'h14, 32'h11223344, 32'h0,        0, "d3_st_w14");

        begin
            exp_t e;
            e.rd = 32'hCAFEF00D; e.err = 1'b0; e.tag = "d3_b2b";
            repeat (3) q3.push_back(e);
        end
        @(posedge clk); #1;
        b2b3 = 1'b1;
        last_acc3 = -1;
        set_bus(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (if3.req_ready) cnt++;
            if (cnt == 3) break;
        end
        chk("d3_b2b_accepts", 32'(cnt), 32'd3);
        @(posedge clk); #1;
        set_bus(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (q3.size() == 0) break;
        end
        chk("d3_b2b_drained", 32'(q3.size()), 32'd0);
        $display("txn dut3 d3_b2b three back-to-back loads of word 0x00");
        @(negedge clk);
        b2b3 = 1'b0;

        // Reset in the middle of a pending store: no response, no write.
        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 32'h99999999);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if3.req_ready) begin cnt = 1; break; end
        end
        chk("d3_rstst_accept", 32'(cnt), 32'd1);
        @(posedge clk); #1;
        set_bus(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        seen_before = resp_seen[1];
        @(posedge clk);
        @(posedge clk); #1;
        rst3_n = 1'b0;
        @(negedge clk);
        chk("d3_ready_in_rst", 32'(if3.req_ready), 32'd0);
        @(posedge clk); #1;
        rst3_n = 1'b1;
        @(negedge clk);
        chk("d3_ready_after_midrst", 32'(if3.req_ready), 32'd1);
        repeat (10) @(negedge clk);
        chk("d3_no_resp_after_rst", 32'(resp_seen[1] - seen_before), 32'd0);
        $display("txn dut3 d3_rst_store store 0x14 dropped by reset");
        do_req(1, 0, 2'b10, 0, 32'h14, 32'h0, 32'h11223344, 0, "d3_ld_w14_kept");

        repeat (3) @(negedge clk);
        chk("dut0_queue_empty", 32'(q0.size()), 32'd0);
        chk("dut3_queue_empty", 32'(q3.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
